// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers per-source results in FIFOs and grants one per cycle onto a registered CDB
module cdb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 3,
  parameter int DATA_W     = 16,
  parameter int ARB_MODE   = 0,
  localparam int SW        = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SW-1:0]             cdb_src
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = TAG_W + DATA_W;
  logic [EW-1:0]      mem_q [NUM_SRC][FIFO_DEPTH];
  logic [PW-1:0]      rd_q  [NUM_SRC];
  logic [PW-1:0]      rd_d  [NUM_SRC];
  logic [PW-1:0]      wr_q  [NUM_SRC];
  logic [PW-1:0]      wr_d  [NUM_SRC];
  logic [CW-1:0]      cnt_q [NUM_SRC];
  logic [CW-1:0]      cnt_d [NUM_SRC];
  logic [SW-1:0]      last_q, gnt;
  logic [NUM_SRC-1:0] req, push, pop;
  logic               any_req, fire, clr;
  logic [EW-1:0]      head;
  int                 j;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    gnt = '0;
    j = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      req[i] = cnt_q[i] != '0;
      src_ready[i] = cnt_q[i] < CW'(FIFO_DEPTH);
    end
    any_req = |req;
    // scan from the far end so the candidate nearest the search start is assigned last and wins
    for (int k = NUM_SRC; k >= 1; k--) begin
      j = (ARB_MODE == 1) ? k - 1 : int'(last_q) + k;
      j = (j >= NUM_SRC) ? j - NUM_SRC : j;
      gnt = req[SW'(j)] ? SW'(j) : gnt;
    end
    clr = ~reset_n | flush;
    fire = any_req & ~flush;
    head = mem_q[gnt][rd_q[gnt]];
    for (int i = 0; i < NUM_SRC; i++) begin
      push[i] = src_valid[i] & src_ready[i] & ~flush;
      pop[i] = fire & (gnt == SW'(i));
      wr_d[i] = push[i] ? inc(wr_q[i]) : wr_q[i];
      rd_d[i] = pop[i] ? inc(rd_q[i]) : rd_q[i];
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      cnt_q[i] <= clr ? '0 : cnt_d[i];
      rd_q[i]  <= clr ? '0 : rd_d[i];
      wr_q[i]  <= clr ? '0 : wr_d[i];
      if (push[i]) mem_q[i][wr_q[i]] <= {src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]};
    end
    if (!reset_n) begin
      last_q    <= SW'(NUM_SRC - 1);
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else begin
      cdb_valid <= fire;
      if (fire) begin
        last_q   <= gnt;
        cdb_tag  <= head[EW-1:DATA_W];
        cdb_data <= head[DATA_W-1:0];
        cdb_src  <= gnt;
      end
    end
  end
endmodule
